// File: rtl/fle_ccff_pkg.sv
// rtl/fle_ccff_pkg.sv - shared types and constants for the fle ccff chain loader.
package fle_ccff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic int word_count(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/fle_ccff_crc16.sv
// rtl/fle_ccff_crc16.sv - serial CRC-16-CCITT, one bit per enabled cycle, MSB-first feedback.
module fle_ccff_crc16
  import fle_ccff_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;
  assign fb = crc[15] ^ din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/fle_ccff_chain_loader.sv
// rtl/fle_ccff_chain_loader.sv - serialises config words onto an fle ccff chain.
// Optional circular CRC read-back of the chain under FLE_CCFF_VERIFY_EN.
module fle_ccff_chain_loader
  import fle_ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NW      = word_count(CHAIN_LEN, WORD_W);
  localparam int BITS_W  = $clog2(CHAIN_LEN + 1);
  localparam int WORDS_W = $clog2(NW + 1);
  localparam int WBIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [BITS_W-1:0]  LAST_BIT  = BITS_W'(CHAIN_LEN - 1);
  localparam logic [WBIT_W-1:0]  LAST_WBIT = WBIT_W'(WORD_W - 1);
  localparam logic [WORDS_W-1:0] NW_MAX    = WORDS_W'(NW);

  state_t               state;
  logic [WORD_W-1:0]    sreg;
  logic [BITS_W-1:0]    bits_sent;
  logic [WBIT_W-1:0]    wbit;
  logic [WORDS_W-1:0]   words_taken;
  logic                 last_bit;
  logic                 start_ok;

  // A word ends either at its own width or when the chain is full (tail bits dropped).
  assign last_bit = (wbit == LAST_WBIT) || (bits_sent == LAST_BIT);
  assign start_ok = cfg_start && !cfg_abort && (state == ST_IDLE || state == ST_DONE);

`ifdef FLE_CCFF_VERIFY_EN
  localparam int VCNT_W = $clog2(CHAIN_LEN + 2);
  localparam logic [VCNT_W-1:0] V_RECIRC_LAST = VCNT_W'(CHAIN_LEN);
  localparam logic [VCNT_W-1:0] V_END         = VCNT_W'(CHAIN_LEN + 1);

  logic [VCNT_W-1:0] vcnt;
  logic [15:0]       crc_tx;
  logic [15:0]       crc_rx;
  logic              tx_en;
  logic              rx_en;

  // The head register makes the read-back ring CHAIN_LEN+1 long: the first tail
  // sample is stale and skipped, and one extra rotation restores the chain.
  assign tx_en = (state == ST_SHIFT) && !cfg_abort;
  assign rx_en = (state == ST_VERIFY) && !cfg_abort && (vcnt != '0) && (vcnt <= V_RECIRC_LAST);

  fle_ccff_crc16 u_crc_tx (
    .clk (prog_clk),
    .rst (pReset),
    .clr (start_ok),
    .en  (tx_en),
    .din (sreg[0]),
    .crc (crc_tx)
  );

  fle_ccff_crc16 u_crc_rx (
    .clk (prog_clk),
    .rst (pReset),
    .clr (start_ok),
    .en  (rx_en),
    .din (ccff_tail),
    .crc (crc_rx)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state          <= ST_IDLE;
      sreg           <= '0;
      bits_sent      <= '0;
      wbit           <= '0;
      words_taken    <= '0;
      cfg_ready      <= 1'b0;
      ccff_head      <= 1'b0;
      chain_shift_en <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef FLE_CCFF_VERIFY_EN
      vcnt           <= '0;
`endif
    end else if (cfg_abort) begin
      if (state != ST_IDLE) begin
        state          <= ST_IDLE;
        cfg_ready      <= 1'b0;
        chain_shift_en <= 1'b0;
        busy           <= 1'b0;
        done           <= 1'b0;
        err            <= 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          chain_shift_en <= 1'b0;
          if (cfg_start) begin
            state       <= ST_FETCH;
            cfg_ready   <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            bits_sent   <= '0;
            wbit        <= '0;
            words_taken <= '0;
`ifdef FLE_CCFF_VERIFY_EN
            vcnt        <= '0;
`endif
          end
        end
        ST_FETCH: begin
          chain_shift_en <= 1'b0;
          if (cfg_valid && cfg_ready) begin
            sreg      <= cfg_word;
            cfg_ready <= 1'b0;
            wbit      <= '0;
            state     <= ST_SHIFT;
            if (words_taken != NW_MAX) begin
              words_taken <= words_taken + 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          ccff_head      <= sreg[0];
          chain_shift_en <= 1'b1;
          sreg           <= sreg >> 1;
          bits_sent      <= bits_sent + 1'b1;
          wbit           <= wbit + 1'b1;
          if (last_bit) begin
            if (bits_sent == LAST_BIT) begin
`ifdef FLE_CCFF_VERIFY_EN
              state <= ST_VERIFY;
              vcnt  <= '0;
`else
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              state     <= ST_FETCH;
              cfg_ready <= 1'b1;
            end
          end
        end
`ifdef FLE_CCFF_VERIFY_EN
        ST_VERIFY: begin
          if (vcnt == V_END) begin
            chain_shift_en <= 1'b0;
            state          <= ST_DONE;
            busy           <= 1'b0;
            if (crc_tx == crc_rx) begin
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            ccff_head      <= ccff_tail;
            chain_shift_en <= 1'b1;
            vcnt           <= vcnt + 1'b1;
          end
        end
`endif
        default: begin
          state          <= ST_IDLE;
          chain_shift_en <= 1'b0;
          cfg_ready      <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule
